// File: rtl/ws281x_pkg.sv
// ws281x_pkg: shared colour-order codes, FSM states and timing/word helpers for the WS281x driver.
package ws281x_pkg;
  localparam logic [1:0] ORDER_GRB = 2'd0;
  localparam logic [1:0] ORDER_RGB = 2'd1;
  localparam logic [1:0] ORDER_BRG = 2'd2;
  typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_LOAD, ST_SEND, ST_LATCH} state_e;
  function automatic int ns_to_cycles(longint clk_hz, longint ns);
    return int'((clk_hz / 1000 * ns) / 1000000);
  endfunction
  // Code 3 is a reserved alias of GRB.
  function automatic logic [23:0] build_word(logic [1:0] order, logic [7:0] r, logic [7:0] g, logic [7:0] b);
    return (order == ORDER_GRB || order == 2'd3) ? {g, r, b} : order == ORDER_RGB ? {r, g, b} : {b, r, g};
  endfunction
endpackage

// File: rtl/ws281x_multilane_driver_lane.sv
// ws281x_lane: per-string shift/shadow registers and the high-time compare that forms one dout bit.
module ws281x_lane #(
  parameter int CW    = 5,
  parameter int T0H_C = 8,
  parameter int T1H_C = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          cap,
  input  logic          shift,
  input  logic          swap,
  input  logic          send,
  input  logic [CW-1:0] cnt,
  input  logic [23:0]   word,
  output logic          dout
);
  logic [23:0] sh_q, sh_d, shadow_q, shadow_d;
  always_comb begin
    sh_d     = load ? word : swap ? shadow_q : shift ? {sh_q[22:0], 1'b0} : sh_q;
    shadow_d = cap ? word : shadow_q;
    dout     = send && (cnt < (sh_q[23] ? CW'(T1H_C) : CW'(T0H_C)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      shadow_q <= '0;
    end else begin
      sh_q     <= sh_d;
      shadow_q <= shadow_d;
    end
  end
endmodule

// File: rtl/ws281x_multilane_driver.sv
// ws281x_multilane_driver: NUM_LANES parallel WS281x strings sharing one bit timer and pixel address.
module ws281x_multilane_driver
  import ws281x_pkg::*;
#(
  parameter int CLK_HZ    = 24000000,
  parameter int NUM_LEDS  = 64,
  parameter int NUM_LANES = 4,
  parameter int T0H_NS    = 350,
  parameter int T1H_NS    = 700,
  parameter int BIT_NS    = 1250,
  parameter int RESET_US  = 60,
  localparam int ADDR_W   = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   free_run,
  input  logic [1:0]             colour_order,
  output logic [ADDR_W-1:0]      address,
  input  logic [8*NUM_LANES-1:0] red_in,
  input  logic [8*NUM_LANES-1:0] green_in,
  input  logic [8*NUM_LANES-1:0] blue_in,
  output logic                   busy,
  output logic                   frame_done,
  output logic [NUM_LANES-1:0]   dout
);
  localparam int T0H_C = ns_to_cycles(CLK_HZ, T0H_NS);
  localparam int T1H_C = ns_to_cycles(CLK_HZ, T1H_NS);
  localparam int BIT_C = ns_to_cycles(CLK_HZ, BIT_NS);
  localparam int RST_C = CLK_HZ / 1000000 * RESET_US;
  localparam int CW    = $clog2(BIT_C);
  localparam int LW    = RST_C > 1 ? $clog2(RST_C) : 1;
  localparam logic [CW-1:0]     BIT_LAST  = CW'(BIT_C - 1);
  localparam logic [LW-1:0]     RST_LAST  = LW'(RST_C - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);
  if (!(T0H_C > 0 && T0H_C < T1H_C && T1H_C < BIT_C && RST_C > 0)) begin : g_bad_timing
    $error("ws281x: need 0 < T0H_C < T1H_C < BIT_C and RST_C > 0");
  end
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [4:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic              last_q, last_d, done_q, done_d;
  logic              load, cap, shift, swap, at_end;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    lat_d   = lat_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    cap     = 1'b0;
    shift   = 1'b0;
    swap    = 1'b0;
    at_end  = cnt_q == BIT_LAST;
    case (state_q)
      ST_IDLE: if (start || free_run) begin
        state_d = ST_FETCH;
        addr_d  = '0;
      end
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD: begin
        load    = 1'b1;
        idx_d   = 5'd23;
        cnt_d   = '0;
        last_d  = 1'b0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        cnt_d = at_end ? '0 : cnt_q + 1'b1;
        // Fetch the next pixel during the last bit so the shadow is ready at the boundary.
        if (idx_q == 5'd0 && cnt_q == '0) begin
          last_d = addr_q == LAST_ADDR;
          addr_d = last_d ? addr_q : addr_q + 1'b1;
        end
        cap = idx_q == 5'd0 && cnt_q == CW'(1) && !last_q;
        if (at_end) begin
          if (idx_q != 5'd0) begin
            shift = 1'b1;
            idx_d = idx_q - 5'd1;
          end else if (last_q) begin
            state_d = ST_LATCH;
            lat_d   = '0;
          end else begin
            swap  = 1'b1;
            idx_d = 5'd23;
          end
        end
      end
      ST_LATCH: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == RST_LAST) begin
          done_d  = 1'b1;
          addr_d  = '0;
          state_d = free_run ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      lat_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end
  assign address    = addr_q;
  assign busy       = state_q != ST_IDLE;
  assign frame_done = done_q;
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ws281x_lane #(.CW(CW), .T0H_C(T0H_C), .T1H_C(T1H_C)) u_lane (
      .clk  (clk),
      .rst  (reset),
      .load (load),
      .cap  (cap),
      .shift(shift),
      .swap (swap),
      .send (state_q == ST_SEND),
      .cnt  (cnt_q),
      .word (build_word(colour_order, red_in[8*k+:8], green_in[8*k+:8], blue_in[8*k+:8])),
      .dout (dout[k])
    );
  end
endmodule

// File: tb/tb_ws281x_multilane_driver.sv
// tb_ws281x_multilane_driver: scoreboarded check of pulse widths, bit spacing, addressing and frame timing.
module tb_ws281x_multilane_driver;
  localparam int NL = 2;
  localparam int NP = 2;
  localparam int FRAME = 2 + 24 * NP * 30 + 48;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, free_run = 1'b0;
  logic [1:0] colour_order = 2'd0;
  logic [0:0] address;
  logic [8*NL-1:0] red_in, green_in, blue_in;
  logic busy, frame_done;
  logic [NL-1:0] dout;
  logic [7:0] r_tab [NL][NP];
  logic [7:0] g_tab [NL][NP];
  logic [7:0] b_tab [NL][NP];
  int checks = 0, errors = 0, cyc = 0;
  int exp_q [NL][$];
  int hi [NL];
  int last_rise [NL];
  logic [NL-1:0] prev = '0;
  bit mon_en = 1'b1;
  logic [0:0] prev_addr = 1'b0;
  int up_cnt = 0, up_first = -1;

  ws281x_multilane_driver #(
    .CLK_HZ(24000000), .NUM_LEDS(NP), .NUM_LANES(NL), .RESET_US(2)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .free_run(free_run), .colour_order(colour_order),
    .address(address), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .busy(busy), .frame_done(frame_done), .dout(dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar k = 0; k < NL; k++) begin : g_up
    assign red_in[8*k+:8]   = r_tab[k][address];
    assign green_in[8*k+:8] = g_tab[k][address];
    assign blue_in[8*k+:8]  = b_tab[k][address];
  end

  function automatic logic [23:0] exp_word(logic [1:0] o, logic [7:0] r, logic [7:0] g, logic [7:0] b);
    case (o)
      2'd1:    return {r, g, b};
      2'd2:    return {b, r, g};
      default: return {g, r, b};
    endcase
  endfunction

  task automatic push_frame();
    logic [23:0] w;
    for (int k = 0; k < NL; k++)
      for (int p = 0; p < NP; p++) begin
        w = exp_word(colour_order, r_tab[k][p], g_tab[k][p], b_tab[k][p]);
        for (int i = 23; i >= 0; i--) exp_q[k].push_back(w[i] ? 16 : 8);
      end
  endtask

  task automatic set_pix(input int k, input int p, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    r_tab[k][p] = r;
    g_tab[k][p] = g;
    b_tab[k][p] = b;
  endtask

  task automatic pulse_start(output int e);
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dc, output int bl);
    dc = -1;
    bl = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frame_done) begin
        dc = cyc;
        return;
      end
      if (!busy) bl++;
    end
  endtask

  // Pulse monitor: pops one expected high time per falling edge and checks rise spacing inside a frame.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < NL; k++) begin
        if (dout[k]) hi[k] = hi[k] + 1;
        if (dout[k] && !prev[k]) begin
          if (cyc - last_rise[k] < 60) begin
            checks++;
            if (cyc - last_rise[k] !== 30) begin
              errors++;
              $display("FAIL bit_period lane %0d cyc %0d: got %0d want 30", k, cyc, cyc - last_rise[k]);
            end
          end
          last_rise[k] = cyc;
        end
        if (!dout[k] && prev[k]) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL high_time lane %0d cyc %0d: got unexpected pulse of %0d", k, cyc, hi[k]);
          end else begin
            int e;
            e = exp_q[k].pop_front();
            if (hi[k] !== e) begin
              errors++;
              $display("FAIL high_time lane %0d cyc %0d: got %0d want %0d", k, cyc, hi[k], e);
            end
          end
          hi[k] = 0;
        end
        prev[k] = dout[k];
      end
    end
  end

  always @(negedge clk) begin
    if (address != prev_addr && address == 1'b1) begin
      up_cnt++;
      if (up_first < 0) up_first = cyc;
    end
    prev_addr = address;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 4;
    if (dout !== 2'b00) begin errors++; $display("FAIL reset_dout: got %b want 00", dout); end
    if (address !== 1'b0) begin errors++; $display("FAIL reset_address: got %b want 0", address); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", frame_done); end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_grb_stream();
    int e, dc, bl;
    colour_order = 2'd0;
    set_pix(0, 0, 8'hFF, 8'h00, 8'h81);
    set_pix(0, 1, 8'h12, 8'h34, 8'h56);
    set_pix(1, 0, 8'h0F, 8'hF0, 8'h3C);
    set_pix(1, 1, 8'hC3, 8'h5A, 8'hA5);
    push_frame();
    up_cnt = 0;
    up_first = -1;
    pulse_start(e);
    wait_done(3000, dc, bl);
    checks += 6;
    if (dc !== e + FRAME) begin errors++; $display("FAIL grb_done_time: got %0d want %0d", dc, e + FRAME); end
    if (bl !== 0) begin errors++; $display("FAIL grb_busy_low: got %0d cycles want 0", bl); end
    if (busy !== 1'b0) begin errors++; $display("FAIL grb_busy_at_done: got %b want 0", busy); end
    if (up_first !== e + 693) begin errors++; $display("FAIL addr_step_time: got %0d want %0d", up_first, e + 693); end
    if (up_cnt !== 1) begin errors++; $display("FAIL addr_step_count: got %0d want 1", up_cnt); end
    if (address !== 1'b0) begin errors++; $display("FAIL addr_after_done: got %b want 0", address); end
    @(negedge clk);
    checks += 3;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", frame_done); end
    if (exp_q[0].size() !== 0) begin errors++; $display("FAIL grb_lane0_left: got %0d want 0", exp_q[0].size()); end
    if (exp_q[1].size() !== 0) begin errors++; $display("FAIL grb_lane1_left: got %0d want 0", exp_q[1].size()); end
  endtask

  task automatic test_orders();
    int e, dc, bl;
    logic [1:0] ords [3] = '{2'd1, 2'd2, 2'd3};
    set_pix(0, 0, 8'hFF, 8'h00, 8'h81);
    set_pix(0, 1, 8'h01, 8'h80, 8'h7E);
    set_pix(1, 0, 8'h80, 8'h01, 8'h00);
    set_pix(1, 1, 8'h00, 8'hAA, 8'h55);
    for (int i = 0; i < 3; i++) begin
      colour_order = ords[i];
      push_frame();
      pulse_start(e);
      wait_done(3000, dc, bl);
      repeat (2) @(negedge clk);
      checks += 3;
      if (dc !== e + FRAME) begin errors++; $display("FAIL order%0d_done_time: got %0d want %0d", ords[i], dc, e + FRAME); end
      if (exp_q[0].size() !== 0) begin errors++; $display("FAIL order%0d_lane0_left: got %0d want 0", ords[i], exp_q[0].size()); end
      if (exp_q[1].size() !== 0) begin errors++; $display("FAIL order%0d_lane1_left: got %0d want 0", ords[i], exp_q[1].size()); end
    end
    colour_order = 2'd0;
  endtask

  task automatic test_back_to_back();
    int e, dc, bl, extra_done, extra_busy, dummy;
    push_frame();
    pulse_start(e);
    repeat (300) @(negedge clk);
    pulse_start(dummy);
    wait_done(3000, dc, bl);
    extra_done = 0;
    extra_busy = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (frame_done) extra_done++;
      if (busy) extra_busy++;
    end
    checks += 4;
    if (dc !== e + FRAME) begin errors++; $display("FAIL b2b_done_time: got %0d want %0d", dc, e + FRAME); end
    if (extra_done !== 0) begin errors++; $display("FAIL b2b_extra_frames: got %0d want 0", extra_done); end
    if (extra_busy !== 0) begin errors++; $display("FAIL b2b_extra_busy: got %0d want 0", extra_busy); end
    if (exp_q[0].size() + exp_q[1].size() !== 0) begin
      errors++; $display("FAIL b2b_left: got %0d want 0", exp_q[0].size() + exp_q[1].size());
    end
  endtask

  task automatic test_free_run_and_abort();
    int e, d1, d2, bl1, bl2, found, late_busy, late_done;
    push_frame();
    push_frame();
    @(negedge clk);
    free_run = 1'b1;
    e = cyc + 1;
    wait_done(3000, d1, bl1);
    checks += 2;
    if (d1 !== e + FRAME) begin errors++; $display("FAIL fr_done1_time: got %0d want %0d", d1, e + FRAME); end
    if (busy !== 1'b1) begin errors++; $display("FAIL fr_busy_at_done: got %b want 1", busy); end
    wait_done(3000, d2, bl2);
    mon_en = 1'b0;
    checks += 3;
    if (d2 - d1 !== FRAME) begin errors++; $display("FAIL fr_period: got %0d want %0d", d2 - d1, FRAME); end
    if (bl1 + bl2 !== 0) begin errors++; $display("FAIL fr_busy_low: got %0d want 0", bl1 + bl2); end
    if (exp_q[0].size() + exp_q[1].size() !== 0) begin
      errors++; $display("FAIL fr_left: got %0d want 0", exp_q[0].size() + exp_q[1].size());
    end
    repeat (200) @(negedge clk);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (dout[0]) found = 1;
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL abort_dout_high: got %0d want 1", found); end
    reset = 1'b1;
    free_run = 1'b0;
    #1;
    checks += 2;
    if (dout !== 2'b00) begin errors++; $display("FAIL abort_dout: got %b want 00", dout); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    late_busy = 0;
    late_done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) late_busy++;
      if (frame_done) late_done++;
    end
    checks += 2;
    if (late_busy !== 0) begin errors++; $display("FAIL abort_resumed_busy: got %0d want 0", late_busy); end
    if (late_done !== 0) begin errors++; $display("FAIL abort_resumed_done: got %0d want 0", late_done); end
    for (int k = 0; k < NL; k++) begin
      exp_q[k].delete();
      hi[k] = 0;
      last_rise[k] = -1000;
    end
    prev = dout;
    mon_en = 1'b1;
  endtask

  task automatic test_restart_after_abort();
    int e, dc, bl;
    push_frame();
    pulse_start(e);
    wait_done(3000, dc, bl);
    repeat (2) @(negedge clk);
    checks += 2;
    if (dc !== e + FRAME) begin errors++; $display("FAIL restart_done_time: got %0d want %0d", dc, e + FRAME); end
    if (exp_q[0].size() + exp_q[1].size() !== 0) begin
      errors++; $display("FAIL restart_left: got %0d want 0", exp_q[0].size() + exp_q[1].size());
    end
  endtask

  initial begin
    for (int k = 0; k < NL; k++) begin
      hi[k] = 0;
      last_rise[k] = -1000;
      for (int p = 0; p < NP; p++) set_pix(k, p, 8'h00, 8'h00, 8'h00);
    end
    test_reset();
    test_grb_stream();
    test_orders();
    test_back_to_back();
    test_free_run_and_abort();
    test_restart_after_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ws281x_multilane_driver.md
Name: ws281x_multilane_driver

Overview:
Parametrised successor to the single-string WS2811 driver. Drives NUM_LANES parallel WS281x strings of NUM_LEDS pixels each, from one shared bit timer. Timing is derived from CLK_HZ and per-bit nanosecond parameters, and colour byte order is selectable at run time. It supports single-shot or free-running frames with a start/busy/done handshake. It sits between the animation/LED-controller logic, which answers address with per-lane colours, and the chip output pins.

Parameters:
CLK_HZ, 24000000, frequency of clk in Hz
NUM_LEDS, 64, pixels per lane (>=1)
NUM_LANES, 4, parallel output strings (>=1)
T0H_NS, 350, high time of a 0 bit
T1H_NS, 700, high time of a 1 bit
BIT_NS, 1250, total bit period
RESET_US, 60, low latch time after a frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
free_run  in  1  when 1, a new frame starts automatically after each latch
colour_order  in  2  0=GRB, 1=RGB, 2=BRG, 3=GRB (reserved alias)
address  out  ADDR_W=$clog2(NUM_LEDS)  pixel index requested from upstream
red_in  in  8*NUM_LANES  lane k at bits [8k+7:8k]
green_in  in  8*NUM_LANES  same packing
blue_in  in  8*NUM_LANES  same packing
busy  out  1  high from frame start until latch ends
frame_done  out  1  one-cycle pulse at end of latch
dout  out  NUM_LANES  serial data per lane

Behaviour:
- Cycle constants are truncating integer maths:
  - T0H_C = (CLK_HZ/1000*T0H_NS)/1000000
  - T1H_C = (CLK_HZ/1000*T1H_NS)/1000000
  - BIT_C = (CLK_HZ/1000*BIT_NS)/1000000
  - RST_C = CLK_HZ/1000000*RESET_US
  - At defaults: 8, 16, 30, 1440.
- Elaboration assertion: 0 < T0H_C < T1H_C < BIT_C.
- Reset state: dout=0, address=0, busy=0, frame_done=0, FSM=IDLE, all counters 0. Reset asserted mid-frame forces dout low within the same cycle (async); the aborted frame is not resumed.
- Upstream read contract: colour inputs are valid one clk after address changes and are held until address changes again. The driver samples them exactly one cycle after driving the address.
- Word build per lane, 24 bits, MSB sent first:
  - GRB: {g,r,b}
  - RGB: {r,g,b}
  - BRG: {b,r,g}
  - colour_order is sampled when each word is loaded.
- FSM:
  - IDLE: dout=0, busy=0. Leaves on start (or free_run) by driving address=0 and going to FETCH.
  - FETCH (1 cycle): go to LOAD.
  - LOAD (1 cycle): capture all lane words into shift registers; bit_idx=23; go to SEND.
  - SEND:
    - bit counter runs 0..BIT_C-1.
    - dout[k] = 1 while counter < (current MSB of lane k ? T1H_C : T0H_C), else 0.
    - At counter=BIT_C-1: shift left, decrement bit_idx.
  - PREFETCH inside SEND: at counter=0 of bit_idx=0, if the pixel is not the last one, increment address. At counter=1, capture the next words into shadow registers. At the bit boundary, shadow moves to shift, so there is no gap between pixels. Every bit period is exactly BIT_C cycles across pixel boundaries.
  - After bit 0 of the last pixel: go to LATCH.
  - LATCH: dout=0 for RST_C cycles. Then pulse frame_done for 1 cycle and set address=0. If free_run=1, go to FETCH; otherwise go to IDLE.
- busy is high in FETCH, LOAD, SEND and LATCH. It drops in the cycle frame_done pulses, unless free_run keeps it high.
- start while busy is ignored (not queued). start and free_run together from IDLE start one frame.
- Frame duration from start to frame_done: 2 + 24*NUM_LEDS*BIT_C + RST_C cycles.
- NUM_LEDS=1: no prefetch occurs; address stays 0.

Decomposition:
- Package ws281x_pkg holds:
  - colour-order constants ORDER_GRB/ORDER_RGB/ORDER_BRG;
  - the FSM state enum;
  - function ns_to_cycles(clk_hz, ns);
  - function build_word(order, r, g, b) returning 24 bits.
- Sub-module ws281x_lane, one per lane via generate, contains:
  - 24-bit shift and shadow registers;
  - load and shift strobes;
  - high-time compare producing its dout bit.
- Top level owns the bit counter, bit_idx, address, latch counter and FSM.

Test Plan:
- Bench configuration for all scenarios: CLK_HZ=24e6, NUM_LEDS=2, NUM_LANES=2, RESET_US=2.
- Lane0 pixel0 = r=FF,g=00,b=81, order GRB, one start pulse. Required on dout[0]: bit stream 00000000_11111111_10000001. Each 1 bit is 16 cycles high then 14 low; each 0 bit is 8 high then 22 low.
- Pixel boundary: measure rising edges of dout across bit 23→24 → spacing exactly 30 cycles; address goes 0→1 once, at the start of the last bit of pixel 0.
- colour_order=1, lane1 r=80,g=01,b=00 → lane1 first bit high 16 cycles, bit 15 high 16 cycles, all others 8; lanes are independent.
- Frame timing: start at cycle T → frame_done pulse at T+2+1440+48 (48 = RST_C at RESET_US=2), busy high throughout. A second start mid-frame produces no extra frame.
- free_run=1 → frame_done every 1490 cycles, busy stays 1; reset asserted mid-SEND → dout=0 and busy=0 immediately; after release, idle until start.
